alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Pipelined decode stage that turns a 32-bit RV32I instruction word into the command bundle consumed by the 5-bit-operation ALU. The bundle carries the operation code, register addresses, an immediate and an operand-B select. It sits between fetch and execute, with valid/ready handshakes on both sides and one register stage. It is the producer of every ALU `operation` value; no other block generates them.

## Interface
- `DATA_WIDTH`, 32: immediate and PC width.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: synchronous active-low reset.
- `flush`  in  1: discard held and incoming instruction.
- `in_valid`  in  1: fetch offers `in_instr`/`in_pc`.
- `in_ready`  out  1: stage accepts this cycle.
- `in_instr`  in  32: instruction word.
- `in_pc`  in  DATA_WIDTH: instruction address, passed through.
- `out_valid`  out  1: bundle valid.
- `out_ready`  in  1: execute accepts bundle.
- `out_operation`  out  5: ALU operation (`alu_op_t` encoding).
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each: register addresses.
- `out_imm`  out  DATA_WIDTH: immediate for operand B.
- `out_use_imm`  out  1: B = `out_imm`, else B = rs2 data.
- `out_rd_we`  out  1: result is written to `out_rd`.
- `out_illegal`  out  1: unsupported encoding.
- `out_pc`  out  DATA_WIDTH: copy of `in_pc`.

## Operation
- Opcode 0110011 (R-type), selected by funct3/funct7:
  - 000/0000000 → ADD; 000/0100000 → SUB; 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR; 101/0000000 → SRL; 101/0100000 → SRA; 110 → OR; 111 → AND.
  - `out_use_imm`=0.
- Opcode 0010011 (I-type):
  - ADDI, SLTI→SLT, SLTIU→SLTU, XORI, ORI, ANDI: `out_imm` = sign-extended `instr[31:20]`.
  - SLLI, SRLI, SRAI→SRA: `out_imm` = zero-extended `instr[24:20]`.
  - `out_use_imm`=1.
- Opcode 0110111 (LUI):
  - op LUI; `out_imm` = zero-extended `instr[31:12]` (the ALU applies the 12-bit shift).
  - `out_rs1` = 0; `out_use_imm`=1.
- Illegal, giving `out_illegal`=1, `out_rd_we`=0, op ADD:
  - any other opcode;
  - R-type funct7 not 0000000/0100000, or 0100000 with funct3 ∉ {000, 101};
  - shift-immediate with `instr[31:25]` other than 0000000 (or 0100000 for funct3 101).
- `out_rd_we` = legal && rd≠0.
- `out_rs1`/`out_rs2`/`out_rd` are always the raw fields `instr[19:15]`/`[24:20]`/`[11:7]`, except the LUI rs1 rule.

## Timing
- Reset (`rst_n`=0 at an edge): `out_valid`=0 and all payload outputs 0 (`out_operation` = 0 encoding), regardless of handshake state. Reset mid-transfer drops the held bundle.
- `in_ready` = !`out_valid` || `out_ready` (combinational; no combinational path from `in_*` to `out_*`).
- Transfer in on `in_valid`&&`in_ready`; the bundle appears on `out_*` the next cycle. Latency 1, throughput 1 per cycle under continuous `out_ready`.
- While `out_valid`&&!`out_ready`: all `out_*` stable, `in_ready`=0.
- `flush`=1 at an edge: `out_valid`←0 and any same-cycle input is dropped. Flush has priority over accept; reset has priority over flush.
- Simultaneous output handshake and input accept: the new bundle replaces the old, with no bubble.

## Structure
- `common` package holds:
  - `alu_op_t` (5-bit enum: SLL, SLLI, SRL, SRLI, ADD, ADDI, SUB, LUI, XOR, XORI, OR, ORI, AND, ANDI, SLT, SLTU, SRA), shared with the ALU;
  - opcode constants `OP_REG`, `OP_IMM`, `OP_LUI`;
  - funct7 constants `F7_BASE`, `F7_ALT`.
- Sub-module `alu_op_decoder`: purely combinational instruction→bundle mapping.
- The top level holds only the handshake and the output register.

## Test plan
- ADD x3,x1,x2 (`0x002081B3`) → next cycle: ADD, rs1=1, rs2=2, rd=3, use_imm=0, rd_we=1, illegal=0.
- SUB x2,x1,x2 (`0x40208133`) then ADDI x5,x0,-1 (`0xFFF00293`) back-to-back:
  - first: SUB;
  - second: ADDI, imm=`0xFFFFFFFF`, use_imm=1, rd=5;
  - no bubble between them.
- LUI x1,0x12345 (`0x123450B7`) → LUI, imm=`0x00012345`, rs1=0, rd=1, rd_we=1. ADDI x0,x0,0 (`0x00000013`) → rd_we=0, illegal=0.
- ECALL (`0x00000073`) → illegal=1, rd_we=0, op ADD.
- Backpressure:
  - `out_ready` low 3 cycles with `in_valid` held → outputs frozen, `in_ready`=0;
  - on release, each instruction is delivered exactly once, in order.
- Flush and reset:
  - `flush` in the same cycle as an accept → `out_valid`=0 next cycle, and the instruction is never delivered;
  - `rst_n`=0 for one cycle while `out_valid`=1 → `out_valid`=0 and payload 0.

Source files
------------

// File: rtl/common.sv
// ============================================================================
//  Module      : common
//  Description : Shared ALU operation encoding and RV32I field constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package common;

    // Encoding order is fixed: the ALU decodes these exact values.
    typedef enum logic [4:0] {
        SLL, SLLI, SRL, SRLI, ADD, ADDI, SUB, LUI,
        XOR, XORI, OR, ORI, AND, ANDI, SLT, SLTU, SRA
    } alu_op_t;

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

`default_nettype wire

// File: rtl/alu_op_decoder.sv
// ============================================================================
//  Module      : alu_op_decoder
//  Description : Combinational RV32I instruction to ALU command mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decoder
    import common::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    output alu_op_t               operation,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  use_imm,
    output logic                  rd_we,
    output logic                  illegal
);

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_sh;
    logic [DATA_WIDTH-1:0] w_imm_u;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];

    // LUI immediate stays unshifted; the ALU applies the 12-bit shift.
    assign w_imm_i  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign w_imm_sh = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
    assign w_imm_u  = {{(DATA_WIDTH-20){1'b0}}, instr[31:12]};

    assign rs2   = instr[24:20];
    assign rd    = instr[11:7];
    assign rd_we = !illegal && (rd != 5'd0);

    always_comb begin
        operation = ADD;
        imm       = '0;
        use_imm   = 1'b0;
        illegal   = 1'b0;
        rs1       = instr[19:15];
        case (w_opcode)
            OP_REG: begin
                case (w_funct3)
                    3'b000: begin
                        if (w_funct7 == F7_BASE)     operation = ADD;
                        else if (w_funct7 == F7_ALT) operation = SUB;
                        else                         illegal   = 1'b1;
                    end
                    3'b101: begin
                        if (w_funct7 == F7_BASE)     operation = SRL;
                        else if (w_funct7 == F7_ALT) operation = SRA;
                        else                         illegal   = 1'b1;
                    end
                    default: begin
                        if (w_funct7 != F7_BASE) illegal = 1'b1;
                        case (w_funct3)
                            3'b001:  operation = SLL;
                            3'b010:  operation = SLT;
                            3'b011:  operation = SLTU;
                            3'b100:  operation = XOR;
                            3'b110:  operation = OR;
                            default: operation = AND;
                        endcase
                    end
                endcase
            end
            OP_IMM: begin
                use_imm = 1'b1;
                imm     = w_imm_i;
                case (w_funct3)
                    3'b000: operation = ADDI;
                    3'b001: begin
                        imm = w_imm_sh;
                        if (w_funct7 == F7_BASE) operation = SLLI;
                        else                     illegal   = 1'b1;
                    end
                    3'b010: operation = SLT;
                    3'b011: operation = SLTU;
                    3'b100: operation = XORI;
                    3'b101: begin
                        imm = w_imm_sh;
                        if (w_funct7 == F7_BASE)     operation = SRLI;
                        else if (w_funct7 == F7_ALT) operation = SRA;
                        else                         illegal   = 1'b1;
                    end
                    3'b110:  operation = ORI;
                    default: operation = ANDI;
                endcase
            end
            OP_LUI: begin
                operation = LUI;
                use_imm   = 1'b1;
                imm       = w_imm_u;
                rs1       = 5'd0;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) operation = ADD;
    end

endmodule

`default_nettype wire

// File: rtl/alu_decode_stage.sv
// ============================================================================
//  Module      : alu_decode_stage
//  Description : One-register decode stage with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode_stage
    import common::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_operation,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic                  out_use_imm,
    output logic                  out_rd_we,
    output logic                  out_illegal,
    output logic [DATA_WIDTH-1:0] out_pc
);

    alu_op_t               w_operation;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic [4:0]            w_rd;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_use_imm;
    logic                  w_rd_we;
    logic                  w_illegal;
    logic                  w_accept;

    logic                  r_valid;
    logic [4:0]            r_operation;
    logic [4:0]            r_rs1;
    logic [4:0]            r_rs2;
    logic [4:0]            r_rd;
    logic [DATA_WIDTH-1:0] r_imm;
    logic                  r_use_imm;
    logic                  r_rd_we;
    logic                  r_illegal;
    logic [DATA_WIDTH-1:0] r_pc;

    alu_op_decoder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decoder (
        .instr     (in_instr),
        .operation (w_operation),
        .rs1       (w_rs1),
        .rs2       (w_rs2),
        .rd        (w_rd),
        .imm       (w_imm),
        .use_imm   (w_use_imm),
        .rd_we     (w_rd_we),
        .illegal   (w_illegal)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Priority: reset, then flush, then load, then drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_operation <= 5'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_rd_we     <= 1'b0;
            r_illegal   <= 1'b0;
            r_pc        <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_operation <= w_operation;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_imm       <= w_imm;
            r_use_imm   <= w_use_imm;
            r_rd_we     <= w_rd_we;
            r_illegal   <= w_illegal;
            r_pc        <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_operation = r_operation;
    assign out_rs1       = r_rs1;
    assign out_rs2       = r_rs2;
    assign out_rd        = r_rd;
    assign out_imm       = r_imm;
    assign out_use_imm   = r_use_imm;
    assign out_rd_we     = r_rd_we;
    assign out_illegal   = r_illegal;
    assign out_pc        = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
// ============================================================================
//  Module      : tb_alu_decode_stage
//  Description : Self-checking bench for alu_decode_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_decode_stage;
    import common::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   in_instr;
    logic [DW-1:0] in_pc, out_imm, out_pc;
    logic [4:0]    out_operation, out_rs1, out_rs2, out_rd;
    logic          out_use_imm, out_rd_we, out_illegal;

    always #5 clk = ~clk;

    alu_decode_stage #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_operation(out_operation),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_use_imm(out_use_imm), .out_rd_we(out_rd_we), .out_illegal(out_illegal),
        .out_pc(out_pc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        rd_we;
        logic        illegal;
        logic        imm_known;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          m_known = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_zero  = 1'b0;
    vec_t        m;
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode taken straight from the instruction-set rules.
    function automatic vec_t decode_ref(input logic [31:0] w);
        vec_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        alu_op_t     r_ops [8];
        alu_op_t     i_ops [8];
        r_ops = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
        i_ops = '{ADDI, SLLI, SLT, SLTU, XORI, SRLI, ORI, ANDI};
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.instr   = w;
        e.rs1     = w[19:15];
        e.rs2     = w[24:20];
        e.rd      = w[11:7];
        e.illegal = 1'b1;
        if (w[6:0] == 7'h33) begin
            if (f7 == 7'h00) begin
                e.illegal = 1'b0; e.op = r_ops[f3];
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                e.illegal = 1'b0; e.op = SUB;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                e.illegal = 1'b0; e.op = SRA;
            end
            e.use_imm = 1'b0;
        end else if (w[6:0] == 7'h13) begin
            e.use_imm = 1'b1;
            e.imm_known = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.imm = 32'(w[24:20]);
                if (f7 == 7'h00) begin
                    e.illegal = 1'b0; e.op = i_ops[f3];
                end else if (f3 == 3'd5 && f7 == 7'h20) begin
                    e.illegal = 1'b0; e.op = SRA;
                end
            end else begin
                e.imm = 32'($signed(w[31:20]));
                e.illegal = 1'b0;
                e.op = i_ops[f3];
            end
        end else if (w[6:0] == 7'h37) begin
            e.illegal   = 1'b0;
            e.op        = LUI;
            e.imm       = 32'(w[31:12]);
            e.use_imm   = 1'b1;
            e.imm_known = 1'b1;
            e.rs1       = 5'd0;
        end
        if (e.illegal) begin
            e.op = ADD;
            e.imm_known = 1'b0;
        end
        else if (w[6:0] == 7'h33) e.imm_known = 1'b0;
        e.rd_we = !e.illegal && e.rd != 0;
        if (w[6:0] == 7'h33 && !e.illegal) begin
            e.use_imm = 1'b0;
        end
        return e;
    endfunction

    task automatic check_payload(input string tag, input vec_t e, input logic [31:0] pc, input bit with_pc);
        chk({tag, "_op"},      64'(out_operation), 64'(e.op));
        chk({tag, "_rs1"},     64'(out_rs1),       64'(e.rs1));
        chk({tag, "_rs2"},     64'(out_rs2),       64'(e.rs2));
        chk({tag, "_rd"},      64'(out_rd),        64'(e.rd));
        chk({tag, "_rd_we"},   64'(out_rd_we),     64'(e.rd_we));
        chk({tag, "_illegal"}, 64'(out_illegal),   64'(e.illegal));
        if (e.imm_known) begin
            chk({tag, "_imm"},     64'(out_imm),     64'(e.imm));
            chk({tag, "_use_imm"}, 64'(out_use_imm), 64'(e.use_imm));
        end
        if (!e.illegal && e.instr[6:0] == 7'h33)
            chk({tag, "_use_imm"}, 64'(out_use_imm), 64'(0));
        if (with_pc) chk({tag, "_pc"}, 64'(out_pc), 64'(pc));
    endtask

    // One clock: drive at the falling edge, check the model, advance the model.
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rstn);
        @(negedge clk);
        in_valid = v; in_instr = instr; in_pc = pc;
        out_ready = ordy; flush = fl; rst_n = rstn;
        #1;
        if (m_known) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("in_ready",  64'(in_ready),  64'(!m_valid || ordy));
            if (m_valid || m_zero) check_payload("model", m, m_pc, 1'b1);
        end
        if (!rstn) begin
            m_known = 1'b1; m_valid = 1'b0; m_zero = 1'b1;
            m = '0; m.imm_known = 1'b1; m_pc = '0;
        end else if (fl) begin
            m_valid = 1'b0; m_zero = 1'b0;
        end else if (v && (!m_valid || ordy)) begin
            m = decode_ref(instr); m_pc = pc; m_valid = 1'b1; m_zero = 1'b0;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h37;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        tbl[0]  = '{32'h002081B3, ADD,  5'd1, 5'd2,  5'd3, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{32'h40208133, SUB,  5'd1, 5'd2,  5'd2, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{32'hFFF00293, ADDI, 5'd0, 5'd31, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{32'h123450B7, LUI,  5'd0, 5'd3,  5'd1, 32'h00012345, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{32'h00000013, ADDI, 5'd0, 5'd0,  5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{32'h00000073, ADD,  5'd0, 5'd0,  5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{32'h40335393, SRA,  5'd6, 5'd3,  5'd7, 32'h3,        1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{32'h4020C1B3, ADD,  5'd1, 5'd2,  5'd3, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{32'h8000B213, SLTU, 5'd1, 5'd0,  5'd4, 32'hFFFFF800, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{32'h40109093, ADD,  5'd1, 5'd1,  5'd1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{32'h007312B3, SLL,  5'd6, 5'd7,  5'd5, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);

        // Back-to-back table vectors under continuous out_ready.
        for (int i = 0; i <= 11; i++) begin
            if (i < 11) step(1, tbl[i].instr, 32'h1000 + 32'(4 * i), 1, 0, 1);
            else        step(0, 0, 0, 1, 0, 1);
            if (i > 0) begin
                chk("tbl_valid", 64'(out_valid), 64'(1));
                check_payload("tbl", tbl[i-1], 32'h1000 + 32'(4 * (i - 1)), 1'b1);
            end
        end
        step(0, 0, 0, 1, 0, 1);

        // Backpressure: three stalled cycles, then both delivered in order.
        step(1, 32'h002081B3, 32'h2000, 1, 0, 1);
        step(1, 32'h40208133, 32'h2004, 0, 0, 1);
        step(1, 32'h40208133, 32'h2004, 0, 0, 1);
        step(1, 32'h40208133, 32'h2004, 0, 0, 1);
        chk("stall_pc", 64'(out_pc), 64'(32'h2000));
        step(1, 32'h40208133, 32'h2004, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        chk("release_pc", 64'(out_pc), 64'(32'h2004));
        step(0, 0, 0, 1, 0, 1);

        // Flush together with an accept drops the instruction.
        step(1, 32'h123450B7, 32'h3000, 1, 1, 1);
        step(0, 0, 0, 1, 0, 1);
        chk("flush_drop", 64'(out_valid), 64'(0));
        step(0, 0, 0, 1, 0, 1);

        // Reset while a bundle is held.
        step(1, 32'hFFF00293, 32'h4000, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_imm",   64'(out_imm),   64'(0));

        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) != 0);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
